// File: rtl/pulse_burst_gen.sv
// Pulse burst generator driving an up/down counter's clock, reset and select pins,
// with a registered model of the value that counter should hold.
module pulse_burst_gen #(
    parameter int BITS  = 4,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic             clear_first,
    input  logic [BITS-1:0]  len,
    input  logic [DIV_W-1:0] half_period,
    output logic             pulse_out,
    output logic             cnt_rst_out,
    output logic             dir_out,
    output logic             busy,
    output logic             done,
    output logic [BITS-1:0]  expected
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    localparam logic [BITS-1:0]  CNT_ONE = BITS'(1);
    localparam logic [DIV_W-1:0] TMR_ONE = DIV_W'(1);

    state_t           state, state_nx;
    logic [DIV_W-1:0] timer, timer_nx;
    logic [DIV_W-1:0] h_reg, h_nx;
    logic [BITS-1:0]  remaining, remaining_nx;
    logic [BITS-1:0]  expected_nx;
    logic             pulse_nx, cnt_rst_nx, dir_nx, busy_nx, done_nx;
    logic             last;

    // timer counts down from half_period, so a phase lasts half_period + 1 cycles
    assign last = (timer == '0);

    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        h_nx         = h_reg;
        remaining_nx = remaining;
        expected_nx  = expected;
        pulse_nx     = pulse_out;
        cnt_rst_nx   = cnt_rst_out;
        dir_nx       = dir_out;
        busy_nx      = busy;
        done_nx      = 1'b0;

        if (abort && state != S_IDLE) begin
            state_nx   = S_IDLE;
            pulse_nx   = 1'b0;
            cnt_rst_nx = 1'b0;
            busy_nx    = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && len != '0) begin
                        remaining_nx = len;
                        dir_nx       = dir;
                        h_nx         = half_period;
                        timer_nx     = half_period;
                        busy_nx      = 1'b1;
                        if (clear_first) begin
                            state_nx   = S_CLR;
                            cnt_rst_nx = 1'b1;
                        end else begin
                            state_nx = S_HIGH;
                            pulse_nx = 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    if (last) begin
                        expected_nx = '0;
                        cnt_rst_nx  = 1'b0;
                        timer_nx    = h_reg;
                        state_nx    = S_LOW;
                    end else begin
                        timer_nx = timer - TMR_ONE;
                    end
                end
                S_HIGH: begin
                    // the count only lands when a HIGH phase completes
                    if (last) begin
                        remaining_nx = remaining - CNT_ONE;
                        expected_nx  = dir_out ? expected + CNT_ONE : expected - CNT_ONE;
                        pulse_nx     = 1'b0;
                        timer_nx     = h_reg;
                        state_nx     = S_LOW;
                    end else begin
                        timer_nx = timer - TMR_ONE;
                    end
                end
                S_LOW: begin
                    if (last) begin
                        if (remaining == '0) begin
                            state_nx = S_DONE;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = S_HIGH;
                            pulse_nx = 1'b1;
                            timer_nx = h_reg;
                        end
                    end else begin
                        timer_nx = timer - TMR_ONE;
                    end
                end
                S_DONE: begin
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx   = S_IDLE;
                    pulse_nx   = 1'b0;
                    cnt_rst_nx = 1'b0;
                    busy_nx    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pulse_out   <= 1'b0;
            cnt_rst_out <= 1'b0;
            dir_out     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            expected    <= '0;
        end else begin
            state       <= state_nx;
            pulse_out   <= pulse_nx;
            cnt_rst_out <= cnt_rst_nx;
            dir_out     <= dir_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            expected    <= expected_nx;
        end
    end

    // burst parameters are always loaded at accept before being read
    always_ff @(posedge clk) begin
        timer     <= timer_nx;
        h_reg     <= h_nx;
        remaining <= remaining_nx;
    end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Bench for pulse_burst_gen: directed and randomized bursts checked against an
// arithmetic per-cycle model of the burst waveform.
module tb_pulse_burst_gen;

    localparam int BITS  = 4;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             dir;
    logic             clear_first;
    logic [BITS-1:0]  len;
    logic [DIV_W-1:0] half_period;
    logic             pulse_out;
    logic             cnt_rst_out;
    logic             dir_out;
    logic             busy;
    logic             done;
    logic [BITS-1:0]  expected;

    int checks = 0;
    int errors = 0;
    logic [BITS-1:0] model_exp;

    pulse_burst_gen #(.BITS(BITS), .DIV_W(DIV_W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .dir(dir),
        .clear_first(clear_first),
        .len(len),
        .half_period(half_period),
        .pulse_out(pulse_out),
        .cnt_rst_out(cnt_rst_out),
        .dir_out(dir_out),
        .busy(busy),
        .done(done),
        .expected(expected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int t, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, expv);
        end
    endtask

    // Counter value after the t-th edge following accept (t = 0 is the accept edge).
    function automatic logic [BITS-1:0] exp_at(input int t, input int h, input int n,
                                               input bit clr, input bit d, input logic [BITS-1:0] e0);
        int off;
        int u;
        int c;
        int base;
        off = clr ? 2 * h : 0;
        if (clr && t < h) return e0;
        base = clr ? 0 : int'(e0);
        if (t < off) return BITS'(base);
        u = t - off;
        if (u >= 2 * h * n) c = n;
        else c = u / (2 * h) + (((u % (2 * h)) >= h) ? 1 : 0);
        return BITS'(d ? base + c : base - c);
    endfunction

    function automatic bit pulse_at(input int t, input int h, input int n, input bit clr);
        int off;
        int u;
        off = clr ? 2 * h : 0;
        if (t < off || t >= off + 2 * h * n) return 1'b0;
        u = t - off;
        return (u % (2 * h)) < h;
    endfunction

    task automatic set_junk();
        dir         = 1'($urandom_range(0, 1));
        clear_first = 1'($urandom_range(0, 1));
        len         = BITS'($urandom_range(0, 15));
        half_period = DIV_W'($urandom_range(0, 255));
    endtask

    task automatic run_burst(input bit d, input bit clr, input int n, input int hp, input int abort_at);
        int h;
        int total;
        logic [BITS-1:0] e0;
        h = hp + 1;
        total = 2 * h * n + (clr ? 2 * h : 0);
        e0 = model_exp;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; dir = d; clear_first = clr;
        len = BITS'(n); half_period = DIV_W'(hp);
        @(posedge clk);
        for (int t = 0; t <= total + 1; t++) begin
            @(negedge clk);
            if (abort_at >= 0 && t == abort_at + 1) begin
                model_exp = exp_at(abort_at, h, n, clr, d, e0);
                chk("abort_pulse", t, pulse_out, 0);
                chk("abort_cnt_rst", t, cnt_rst_out, 0);
                chk("abort_busy", t, busy, 0);
                chk("abort_done", t, done, 0);
                chk("abort_expected", t, expected, model_exp);
                abort = 1'b0; start = 1'b0;
                @(negedge clk);
                chk("post_abort_done", t + 1, done, 0);
                chk("post_abort_busy", t + 1, busy, 0);
                chk("post_abort_dir", t + 1, dir_out, d);
                return;
            end
            chk("pulse_out", t, pulse_out, pulse_at(t, h, n, clr));
            chk("cnt_rst_out", t, cnt_rst_out, (clr && t < h) ? 1 : 0);
            chk("busy", t, busy, (t < total) ? 1 : 0);
            chk("done", t, done, (t == total) ? 1 : 0);
            chk("expected", t, expected, exp_at(t, h, n, clr, d, e0));
            chk("dir_out", t, dir_out, d);
            set_junk();
            abort = (t == abort_at);
            start = (t <= total) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
        model_exp = exp_at(total, h, n, clr, d, e0);
    endtask

    initial begin
        int n;
        int hp;
        int total;
        int ab;
        bit d;
        bit clr;

        rst = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0;
        clear_first = 1'b0; len = '0; half_period = '0;
        model_exp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pulse", 0, pulse_out, 0);
        chk("rst_cnt_rst", 0, cnt_rst_out, 0);
        chk("rst_dir", 0, dir_out, 0);
        chk("rst_busy", 0, busy, 0);
        chk("rst_done", 0, done, 0);
        chk("rst_expected", 0, expected, 0);
        rst = 1'b0;

        run_burst(1'b1, 1'b0, 3, 1, -1);
        run_burst(1'b0, 1'b1, 5, 0, -1);
        chk("clear_down_result", 0, expected, 11);
        run_burst(1'b1, 1'b0, 3, 2, -1);
        run_burst(1'b1, 1'b0, 4, 0, -1);
        chk("wrap_result", 0, expected, 2);

        // asynchronous reset in the middle of a HIGH phase
        @(negedge clk);
        start = 1'b1; dir = 1'b1; clear_first = 1'b0; len = 4'd3; half_period = 8'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst_pulse", 0, pulse_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pulse", 0, pulse_out, 0);
        chk("async_rst_busy", 0, busy, 0);
        chk("async_rst_expected", 0, expected, 0);
        chk("async_rst_dir", 0, dir_out, 0);
        @(negedge clk);
        rst = 1'b0;
        model_exp = '0;

        run_burst(1'b1, 1'b0, 6, 1, 8);
        chk("abort_result", 0, expected, 2);

        @(negedge clk);
        start = 1'b1; len = '0; dir = 1'b0; half_period = 8'd0; clear_first = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("len0_busy", i, busy, 0);
            chk("len0_done", i, done, 0);
            chk("len0_cnt_rst", i, cnt_rst_out, 0);
            chk("len0_dir", i, dir_out, 1);
        end
        start = 1'b0;

        run_burst(1'b0, 1'b0, 15, 0, -1);

        for (int k = 0; k < 16; k++) begin
            d   = 1'($urandom_range(0, 1));
            clr = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 15);
            hp  = $urandom_range(0, 3);
            total = 2 * (hp + 1) * n + (clr ? 2 * (hp + 1) : 0);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, total - 1) : -1;
            run_burst(d, clr, n, hp, ab);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_burst_gen.md
# pulse_burst_gen

Stimulus generator for the on-chip up/down counter: drives its count clock, reset and direction pins with clean, software-timed pulse bursts. Sits on the transmit side of the counter's pin interface (clock, reset, select), clocked by the system clock. It also keeps a registered model of the count the downstream counter must hold, so the pair can be self-checked on silicon or in simulation. A burst is a programmed number of equal-duty pulses in one direction, optionally preceded by a counter reset pulse.

## Interface

- BITS, 4, width of the driven counter and of `len` / `expected`
- DIV_W, 8, width of the half-period setting
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a burst; sampled only in IDLE
- abort  in  1  synchronous abort; highest priority after rst
- dir  in  1  burst direction, 1 = up, 0 = down; latched at accept
- clear_first  in  1  issue a counter reset pulse before the burst; latched at accept
- len  in  BITS  number of pulses; 0 = request ignored
- half_period  in  DIV_W  phase length H = half_period + 1 cycles; latched at accept
- pulse_out  out  1  count clock to the counter
- cnt_rst_out  out  1  reset to the counter, active-high
- dir_out  out  1  select to the counter
- busy  out  1  burst in progress
- done  out  1  one-cycle completion strobe
- expected  out  BITS  model of the counter value

## Operation

- All outputs registered. Reset values: pulse_out 0, cnt_rst_out 0, dir_out 0, busy 0, done 0, expected 0; state IDLE.
- States: IDLE, CLR, HIGH, LOW, DONE. Phase timer counts H cycles per CLR/HIGH/LOW phase; remaining-pulse register is BITS wide.
- IDLE: `start && len != 0` accepted. Latch len→remaining, dir→dir_out, H, clear_first. busy→1. Next state CLR if clear_first else HIGH. `start` with len = 0 ignored, no done.
- CLR: cnt_rst_out = 1 for H cycles. On last cycle, expected←0, go LOW.
- HIGH: pulse_out = 1 for H cycles. On last cycle, remaining−1 and expected ±1 per dir_out, mod 2^BITS (15+1→0, 0−1→15). Go LOW.
- LOW: pulse_out = 0 for H cycles. On last cycle, go DONE if remaining = 0, else HIGH.
- DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE. start seen in DONE ignored.
- abort: in any non-IDLE state, next edge forces IDLE. pulse_out, cnt_rst_out, busy → 0. No done strobe. expected keeps only updates already made, so a HIGH phase cut short does not count.
- dir_out changes only at accept. It holds its value through IDLE.
- Inputs other than start/abort are don't-care outside the accept cycle.

## Timing

- Accept at edge k: pulse_out (no clear) or cnt_rst_out (clear) high from edge k; busy high from edge k.
- Burst length, accept edge to DONE entry: 2·H·len cycles. With clear_first: 2·H·len + 2·H.
- done asserted the cycle after the final LOW phase. Earliest next accept is the cycle after done.
- Minimum H = 1 (half_period = 0): pulse_out toggles every cycle, 50 % duty.
- len = 2^BITS−1 is the maximum burst. No pulse-count wrap within one burst.
- rst mid-burst: all outputs to reset values immediately (asynchronous), including expected.

## Test plan

- Reset: assert rst mid-HIGH → pulse_out 0, busy 0, expected 0 without a clock edge.
- Basic up: dir=1, len=3, half_period=1, clear_first=0 → pulse_out high 2 / low 2 cycles × 3, done at cycle 12 after accept, expected 0→3.
- Clear then down: expected=3, clear_first=1, dir=0, len=5, half_period=0 → cnt_rst_out high 1 cycle, expected→0, then 5 single-cycle pulses, expected=11, done after 12 cycles.
- Wrap: expected=14, dir=1, len=4 → expected sequence 15,0,1,2.
- Abort: len=6, abort during the third HIGH → IDLE next edge, expected = start+2, no done, pulse_out 0.
- Ignored requests: start with len=0 → busy stays 0, no done. start while busy → no effect on remaining or timing.
